demux1to2_stream: RTL and testbench

- Stream demultiplexer: the opposite direction of the team's 8-bit 2:1 mux.
- Takes one valid/ready byte stream carrying a per-byte select bit and steers each byte to one of two output streams.
- Each output has its own small FIFO, so a stalled consumer does not block bytes bound for the other output once its FIFO drains.
- Sits between the datapath bus and two peripheral/register sinks.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_fifo.sv | 69 ++++++
 rtl/demux1to2_stream.sv | 88 ++++++++
 tb/tb_demux1to2_stream.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1:2 stream demultiplexer: default byte width,
// select encoding and pop-counter width.
package demux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = 16;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO with registered head data.
// A full FIFO refuses a push even when it is popped in the same cycle.
module demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is reset too (it is only DEPTH bytes) so the head reads 0 out of reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// Valid/ready 1:2 stream demultiplexer with one FIFO per output.
// Optional pop counters cnt0/cnt1 are built when DEMUX_COUNT_EN is defined.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic full0, full1, empty0, empty1;
  logic push0, push1, accept;

  // Only the addressed FIFO's full flag gates acceptance; held low during reset.
  assign in_ready = rst_n & ((in_sel == SEL_OUT1) ? ~full1 : ~full0);
  assign accept   = in_valid & in_ready;
  assign push0    = accept & (in_sel == SEL_OUT0);
  assign push1    = accept & (in_sel == SEL_OUT1);

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .full      (full0),
    .empty     (empty0),
    .head_data (out0_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .full      (full1),
    .empty     (empty1),
    .head_data (out1_data)
  );

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out0_valid & out0_ready) cnt0_d = cnt0_q + CNT_W'(1);
    if (out1_valid & out1_ready) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed + scoreboarded testbench for demux1to2_stream.
// Counter checks are compiled in when DEMUX_COUNT_EN is defined.
module tb_demux1to2_stream;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 2;
  localparam int BUDGET = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
`ifdef DEMUX_COUNT_EN
  logic [15:0]      cnt0, cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux1to2_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic s, input logic v);
    in_data  = d;
    in_sel   = s;
    in_valid = v;
    #1;
  endtask

  logic [WIDTH-1:0] q0[$], q1[$];
  int               n_pop0 = 0, n_pop1 = 0;

  initial begin
    int  sent, cycles;
    logic pend, exp_rdy, pop0, pop1, acc;

    rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    // ---- reset state
    #12;
    check("rst_rdy",  in_ready, 0);
    check("rst_v0",   out0_valid, 0);
    check("rst_v1",   out1_valid, 0);
    check("rst_d0",   out0_data, 0);
    check("rst_d1",   out1_data, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("idle_rdy", in_ready, 1);
    check("idle_v0",  out0_valid, 0);
    check("idle_v1",  out1_valid, 0);

    // ---- routing
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(8'hA5, 1'b0, 1'b1);
    check("rt_rdy0", in_ready, 1);
    check("rt_v0_pre", out0_valid, 0);
    cycle();
    check("rt_v0", out0_valid, 1);
    check("rt_d0", out0_data, 8'hA5);
    check("rt_v1_quiet", out1_valid, 0);
    drive(8'h3C, 1'b1, 1'b1);
    check("rt_v1_pre", out1_valid, 0);
    cycle();
    check("rt_v1", out1_valid, 1);
    check("rt_d1", out1_data, 8'h3C);
    check("rt_v0_popped", out0_valid, 0);
    drive(8'h00, 1'b0, 1'b0);
    cycle();
    check("rt_v1_popped", out1_valid, 0);

    // ---- backpressure / full
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(8'h01, 1'b0, 1'b1);
    check("bp_rdy_01", in_ready, 1);
    cycle();
    drive(8'h02, 1'b0, 1'b1);
    check("bp_rdy_02", in_ready, 1);
    cycle();
    drive(8'h03, 1'b0, 1'b1);
    check("bp_full", in_ready, 0);
    check("bp_head", out0_data, 8'h01);
    cycle();
    check("bp_full_hold", in_ready, 0);
    check("bp_head_hold", out0_data, 8'h01);
    check("bp_v0_hold", out0_valid, 1);
    drive(8'h77, 1'b1, 1'b1);
    check("bp_rdy_sel1", in_ready, 1);
    cycle();
    check("bp_v1", out1_valid, 1);
    check("bp_d1", out1_data, 8'h77);
    out0_ready = 1'b1;
    drive(8'h03, 1'b0, 1'b1);
    check("bp_no_passthru", in_ready, 0);
    cycle();
    check("bp_d0_02", out0_data, 8'h02);
    check("bp_rdy_after_pop", in_ready, 1);
    cycle();
    check("bp_v0_03", out0_valid, 1);
    check("bp_d0_03", out0_data, 8'h03);
    drive(8'h00, 1'b0, 1'b0);
    cycle();
    check("bp_v0_empty", out0_valid, 0);
    check("bp_v1_still", out1_valid, 1);
    out1_ready = 1'b1;
    cycle();
    check("bp_v1_empty", out1_valid, 0);

    // ---- simultaneous push/pop at count 1 on out1
    for (int i = 0; i < 16; i++) begin
      drive(WIDTH'(8'h10 + i), 1'b1, 1'b1);
      check("st_rdy", in_ready, 1);
      cycle();
      check("st_v1", out1_valid, 1);
      check("st_d1", out1_data, 32'(8'h10 + i));
    end
    drive(8'h00, 1'b0, 1'b0);
    cycle();
    check("st_v1_drain", out1_valid, 0);

    // ---- mid-stream reset with two bytes buffered
    out0_ready = 1'b0;
    drive(8'hAA, 1'b0, 1'b1);
    cycle();
    drive(8'hBB, 1'b0, 1'b1);
    cycle();
    drive(8'h00, 1'b0, 1'b0);
    check("mr_v0_pre", out0_valid, 1);
    check("mr_d0_pre", out0_data, 8'hAA);
    #1 rst_n = 1'b0;
    #1;
    check("mr_v0", out0_valid, 0);
    check("mr_d0", out0_data, 0);
    check("mr_rdy", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    cycle();
    cycle();
    check("mr_v0_after", out0_valid, 0);
    check("mr_v1_after", out1_valid, 0);

    // ---- random traffic against a per-output scoreboard
    sent = 0; cycles = 0; pend = 1'b0;
    while ((sent < 100 || pend || q0.size() != 0 || q1.size() != 0) && cycles < BUDGET) begin
      if (!pend && sent < 100 && $urandom_range(0, 3) != 0) begin
        in_data = WIDTH'($urandom);
        in_sel  = 1'($urandom_range(0, 1));
        pend    = 1'b1;
        sent++;
      end
      in_valid   = pend;
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      check("rnd_rdy", in_ready, 32'(exp_rdy));
      check("rnd_v0", out0_valid, 32'(q0.size() != 0));
      check("rnd_v1", out1_valid, 32'(q1.size() != 0));
      if (q0.size() != 0) check("rnd_d0", out0_data, 32'(q0[0]));
      if (q1.size() != 0) check("rnd_d1", out1_data, 32'(q1[0]));
      pop0 = out0_ready && (q0.size() != 0);
      pop1 = out1_ready && (q1.size() != 0);
      acc  = pend && exp_rdy;
      cycle();
      if (pop0) begin void'(q0.pop_front()); n_pop0++; end
      if (pop1) begin void'(q1.pop_front()); n_pop1++; end
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
        pend = 1'b0;
      end
      cycles++;
    end
    check("rnd_finished_in_budget", 32'(cycles < BUDGET), 1);
    check("rnd_total_popped", 32'(n_pop0 + n_pop1), 100);
    in_valid = 1'b0;
    #1;
    check("rnd_v0_end", out0_valid, 0);
    check("rnd_v1_end", out1_valid, 0);

`ifdef DEMUX_COUNT_EN
    check("cnt0", 32'(cnt0), 32'(n_pop0 & 16'hFFFF));
    check("cnt1", 32'(cnt1), 32'(n_pop1 & 16'hFFFF));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
